// File: rtl/cache_line_xfer.sv
`default_nettype none
// ============================================================================
// Module      : cache_line_xfer
// Description : Cache-line transfer engine: optional dirty-victim writeback,
//               then a (critical-word-first) refill over a req/ack memory port.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_line_xfer #(
    parameter int ADDR_W     = 32,
    parameter int LINE_WORDS = 8,
    parameter int INDEX_W    = 6,
    parameter int MEM_ADDR_W = 13,
    parameter int CRIT_FIRST = 1,
    localparam int OFF_W     = $clog2(LINE_WORDS),
    localparam int TAG_W     = ADDR_W - INDEX_W - OFF_W - 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     writeback,
    input  logic [ADDR_W-1:0]        cpu_addr,
    input  logic [TAG_W-1:0]         victim_tag,
    output logic [MEM_ADDR_W-1:0]    mem_addr,
    output logic                     mem_rd,
    output logic                     mem_wr,
    output logic [31:0]              mem_wdata,
    input  logic [31:0]              mem_rdata,
    input  logic                     mem_ack,
    output logic [INDEX_W+OFF_W-1:0] cache_addr,
    output logic [31:0]              cache_din,
    output logic                     cache_we,
    input  logic [31:0]              cache_dout,
    output logic                     busy,
    output logic                     done
);

    localparam logic [OFF_W-1:0] c_one  = OFF_W'(1);
    localparam logic [OFF_W-1:0] c_last = OFF_W'(LINE_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WB_RD = 3'd1,
        S_WB_WR = 3'd2,
        S_FILL  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [OFF_W-1:0]     r_count;
    logic [OFF_W-1:0]     r_w0;
    logic [TAG_W-1:0]     r_tag;
    logic [TAG_W-1:0]     r_vtag;
    logic [INDEX_W-1:0]   r_index;
    logic [OFF_W-1:0]     w_word;
    logic                 w_adv;
    logic                 w_unused;

    // Byte-offset bits never address a word.
    assign w_unused  = ^cpu_addr[1:0];

    assign w_word    = r_w0 + r_count;
    assign mem_wdata = cache_dout;
    assign cache_din = mem_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_w0    <= '0;
            r_tag   <= '0;
            r_vtag  <= '0;
            r_index <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && start) begin
                r_count <= '0;
                r_tag   <= cpu_addr[ADDR_W-1 -: TAG_W];
                r_index <= cpu_addr[INDEX_W+OFF_W+1 : OFF_W+2];
                r_w0    <= (CRIT_FIRST != 0) ? cpu_addr[OFF_W+1:2] : '0;
                r_vtag  <= victim_tag;
            end else if (w_adv) begin
                r_count <= r_count + c_one;
            end
        end
    end

    always_comb begin
        w_next     = r_state;
        w_adv      = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        mem_addr   = '0;
        cache_addr = '0;
        cache_we   = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_next = writeback ? S_WB_RD : S_FILL;
                end
            end
            S_WB_RD: begin
                cache_addr = {r_index, r_count};
                w_next     = S_WB_WR;
            end
            S_WB_WR: begin
                // Array address held so the synchronous read data stays valid.
                cache_addr = {r_index, r_count};
                mem_wr     = 1'b1;
                mem_addr   = MEM_ADDR_W'({r_vtag, r_index, r_count});
                if (mem_ack) begin
                    w_adv  = 1'b1;
                    w_next = (r_count == c_last) ? S_FILL : S_WB_RD;
                end
            end
            S_FILL: begin
                cache_addr = {r_index, w_word};
                mem_rd     = 1'b1;
                mem_addr   = MEM_ADDR_W'({r_tag, r_index, w_word});
                cache_we   = mem_ack;
                if (mem_ack) begin
                    w_adv = 1'b1;
                    if (r_count == c_last) begin
                        w_next = S_DONE;
                    end
                end
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_cache_line_xfer.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_line_xfer
// Description : Table-driven bench for cache_line_xfer with array/memory models.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_line_xfer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        writeback = 1'b0;
    logic [31:0] cpu_addr = '0;
    logic [20:0] victim_tag = '0;
    logic [12:0] mem_addr;
    logic        mem_rd, mem_wr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        mem_ack = 1'b0;
    logic [8:0]  cache_addr;
    logic [31:0] cache_din;
    logic        cache_we;
    logic [31:0] cache_dout;
    logic        busy, done;
    logic        init_arr = 1'b1;

    int total = 0;
    int bad   = 0;

    logic [31:0] cache_arr [512];
    logic [31:0] shadow    [512];

    cache_line_xfer dut (
        .clk(clk), .rst(rst), .start(start), .writeback(writeback),
        .cpu_addr(cpu_addr), .victim_tag(victim_tag),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .cache_addr(cache_addr), .cache_din(cache_din), .cache_we(cache_we),
        .cache_dout(cache_dout), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Main memory returns a word derived from its own address.
    assign mem_rdata = 32'h5A00_0000 | {19'd0, mem_addr};

    always @(posedge clk) begin
        if (init_arr) begin
            for (int i = 0; i < 512; i++) cache_arr[i] <= 32'hC0DE_0000 | i;
        end else if (cache_we) begin
            cache_arr[cache_addr] <= cache_din;
        end
        cache_dout <= cache_arr[cache_addr];
    end

    typedef struct {
        logic [31:0] cpu;
        logic [20:0] vtag;
        logic        wb;
        int          ack_per;
        int          exp_done;
        int          w0;
        int          idx;
        logic [12:0] fill_base;
        logic [12:0] wb_base;
        logic        poke;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_mem_rd"},     {31'd0, mem_rd},   32'd0);
        check({tag, "_mem_wr"},     {31'd0, mem_wr},   32'd0);
        check({tag, "_cache_we"},   {31'd0, cache_we}, 32'd0);
        check({tag, "_busy"},       {31'd0, busy},     32'd0);
        check({tag, "_done"},       {31'd0, done},     32'd0);
        check({tag, "_mem_addr"},   {19'd0, mem_addr}, 32'd0);
        check({tag, "_cache_addr"}, {23'd0, cache_addr}, 32'd0);
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        logic [31:0] fa[$];
        logic [31:0] fca[$];
        logic [31:0] wa[$];
        logic [31:0] wd[$];
        int done_cyc = 0;
        int ndone = 0;
        int nwe = 0;
        int hs = 0;
        logic prev_req = 1'b0;
        logic prev_rd = 1'b0;
        logic prev_wr = 1'b0;
        logic [12:0] prev_addr = '0;
        int w;
        @(posedge clk); #1;
        start = 1'b1; cpu_addr = v.cpu; victim_tag = v.vtag; writeback = v.wb; mem_ack = 1'b0;
        for (int cyc = 1; cyc <= 300 && done_cyc == 0; cyc++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (v.poke && cyc == 3) begin
                start = 1'b1; cpu_addr = 32'hFFC; writeback = 1'b1; victim_tag = 21'h1F;
            end
            mem_ack = (cyc % v.ack_per) == 0;
            @(negedge clk);
            if (mem_rd && mem_wr) hs++;
            if (cache_we !== (mem_rd && mem_ack)) hs++;
            if (busy !== 1'b1) hs++;
            if (prev_req && (mem_rd !== prev_rd || mem_wr !== prev_wr || mem_addr !== prev_addr)) hs++;
            if (mem_wr && mem_ack) begin
                wa.push_back({19'd0, mem_addr});
                wd.push_back(mem_wdata);
            end
            if (mem_rd && mem_ack) begin
                fa.push_back({19'd0, mem_addr});
                fca.push_back({23'd0, cache_addr});
            end
            if (cache_we) nwe++;
            if (done) begin
                ndone++;
                done_cyc = cyc;
            end
            prev_req  = (mem_rd || mem_wr) && !mem_ack;
            prev_rd   = mem_rd;
            prev_wr   = mem_wr;
            prev_addr = mem_addr;
        end
        @(posedge clk); #1;
        mem_ack = 1'b0; start = 1'b0;
        @(negedge clk);
        check({nm, "_idle_after"}, {30'd0, busy, done}, 32'd0);
        check({nm, "_done_count"}, ndone, 1);
        if (v.exp_done != 0) check({nm, "_done_cycle"}, done_cyc, v.exp_done);
        check({nm, "_handshake"}, hs, 0);
        check({nm, "_we_count"}, nwe, 8);
        check({nm, "_fill_count"}, fa.size(), 8);
        for (int k = 0; k < 8 && k < fa.size(); k++) begin
            w = (v.w0 + k) % 8;
            check({nm, "_fill_addr"}, fa[k], {19'd0, v.fill_base} + w);
            check({nm, "_fill_caddr"}, fca[k], v.idx * 8 + w);
        end
        check({nm, "_wb_count"}, wa.size(), v.wb ? 8 : 0);
        for (int k = 0; k < 8 && k < wa.size(); k++) begin
            check({nm, "_wb_addr"}, wa[k], {19'd0, v.wb_base} + k);
            check({nm, "_wb_data"}, wd[k], shadow[v.idx * 8 + k]);
        end
        for (int k = 0; k < 8; k++) begin
            shadow[v.idx * 8 + k] = 32'h5A00_0000 | ({19'd0, v.fill_base} + k);
            check({nm, "_array"}, cache_arr[v.idx * 8 + k], shadow[v.idx * 8 + k]);
        end
    endtask

    initial begin
        int nwe;
        vec_t rv;
        for (int i = 0; i < 512; i++) shadow[i] = 32'hC0DE_0000 | i;
        //            cpu        vtag      wb    per done w0 idx fill_base  wb_base   poke
        vecs[0] = '{32'h120,   21'h0,     1'b0, 1, 9,  0, 9,  13'h048, 13'h000, 1'b0};
        vecs[1] = '{32'h12C,   21'h0,     1'b0, 1, 9,  3, 9,  13'h048, 13'h000, 1'b1};
        vecs[2] = '{32'h120,   21'h5,     1'b1, 1, 25, 0, 9,  13'h048, 13'hA48, 1'b0};
        vecs[3] = '{32'h3E4,   21'h0,     1'b0, 3, 25, 1, 31, 13'h0F8, 13'h000, 1'b0};
        vecs[4] = '{32'h12344, 21'h1ABCD, 1'b1, 2, 0,  1, 26, 13'h08D0, 13'h1AD0, 1'b0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b0; init_arr = 1'b0;

        for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Reset four words into a fill of line 0 (tag 1), then restart it.
        nwe = 0;
        @(posedge clk); #1;
        start = 1'b1; cpu_addr = 32'h800; writeback = 1'b0; mem_ack = 1'b1;
        for (int cyc = 1; cyc <= 4; cyc++) begin
            @(posedge clk); #1;
            start = 1'b0;
            @(negedge clk);
            if (cache_we) nwe++;
        end
        @(posedge clk); #1;
        rst = 1'b1; mem_ack = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; mem_ack = 1'b1;
        @(negedge clk);
        check_idle_outputs("abort");
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk);
            if (done || busy) nwe += 100;
        end
        check("abort_writes", nwe, 4);
        for (int k = 0; k < 8; k++) begin
            if (k < 4) shadow[k] = 32'h5A00_0200 | k;
            check("abort_array", cache_arr[k], shadow[k]);
        end
        rv = '{32'h800, 21'h0, 1'b0, 1, 9, 0, 0, 13'h200, 13'h000, 1'b0};
        run_vec(rv, "restart");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
